// File: rtl/wos_filter_pkg.sv
// Shared types and helpers for the rank-order filter sequencer.
// Optional build macro used by the top: FILTER_PERF_EN (adds o_cycles).
package wos_filter_pkg;

    localparam int DIM_W  = 8;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_SETTLE = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // A window of side k must be non-empty, fit the kernel and fit the image.
    function automatic logic legal_geometry(input logic [DIM_W-1:0] h,
                                            input logic [DIM_W-1:0] w,
                                            input logic [DIM_W-1:0] k,
                                            input int               max_n);
        return (k != '0) && (int'(k) <= max_n) && (k <= h) && (k <= w);
    endfunction

endpackage

// File: rtl/wos_addr_gen.sv
// Address generator: row-base, column and output-index counters.
// Read addresses advance by the image width per slot, so no multiplier is needed.
module wos_addr_gen
    import wos_filter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IMG_BASE = 32'h0,
    parameter logic [ADDR_W-1:0] OUT_BASE = 32'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  i_w,
    input  logic              i_row_init,
    input  logic              i_col_init,
    input  logic              i_slot_step,
    input  logic              i_col_next,
    input  logic              i_row_next,
    input  logic              i_wr_step,
    output logic [DIM_W-1:0]  o_col,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_wr_addr
);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] w_ext;

    assign w_ext = ADDR_W'(i_w);

    // Next-state of the counters from the FSM strobes (strobes are mutually exclusive where they overlap).
    always_comb begin
        row_base_d = row_base_q;
        pix_d      = pix_q;
        out_idx_d  = out_idx_q;
        col_d      = col_q;
        if (i_row_init) begin
            row_base_d = IMG_BASE;
            out_idx_d  = '0;
        end
        if (i_col_init) begin
            col_d = '0;
            pix_d = row_base_q;
        end
        if (i_slot_step) begin
            pix_d = pix_q + w_ext;
        end
        if (i_col_next) begin
            col_d = col_q + 1'b1;
            pix_d = row_base_q + ADDR_W'(col_q) + ADDR_W'(1);
        end
        if (i_row_next) begin
            row_base_d = row_base_q + w_ext;
        end
        if (i_wr_step) begin
            out_idx_d = out_idx_q + ADDR_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q <= '0;
            pix_q      <= '0;
            out_idx_q  <= '0;
            col_q      <= '0;
        end else begin
            row_base_q <= row_base_d;
            pix_q      <= pix_d;
            out_idx_q  <= out_idx_d;
            col_q      <= col_d;
        end
    end

    assign o_col     = col_q;
    assign o_rd_addr = pix_q;
    assign o_wr_addr = OUT_BASE + out_idx_q;

endmodule

// File: rtl/wos_filter_sequencer.sv
// Sequencer for the masked rank-order kernel during run_filter.
// Optional feature: define FILTER_PERF_EN to add the o_cycles busy-cycle counter.
module wos_filter_sequencer
    import wos_filter_pkg::*;
#(
    parameter int                MAX_N    = 5,
    parameter logic [ADDR_W-1:0] IMG_BASE = 32'h0,
    parameter logic [ADDR_W-1:0] OUT_BASE = 32'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_h,
    input  logic [DIM_W-1:0]  i_w,
    input  logic [DIM_W-1:0]  i_n,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd_en,
    output logic              o_wr_en,
    output logic              o_kernel_en,
    output logic              o_kernel_clr,
    output logic              o_done,
    output logic              o_err
`ifdef FILTER_PERF_EN
    ,
    output logic [31:0]       o_cycles
`endif
);

    localparam logic [2:0] IDLE   = S_IDLE;
    localparam logic [2:0] CLEAR  = S_CLEAR;
    localparam logic [2:0] FEED   = S_FEED;
    localparam logic [2:0] SETTLE = S_SETTLE;
    localparam logic [2:0] WRITE  = S_WRITE;
    localparam logic [2:0] DONE   = S_DONE;

    localparam int             J_W    = $clog2(MAX_N + 1);
    localparam logic [J_W-1:0] LAST_J = J_W'(MAX_N - 1);

    logic [2:0]       state_q, state_d;
    logic [DIM_W-1:0] h_q, h_d, w_q, w_d, k_q, k_d, r_q, r_d;
    logic [J_W-1:0]   j_q, j_d;
    logic             err_q, err_d;
    logic             ken_q, ken_d;

    logic row_init, col_init, slot_step, col_next, row_next, wr_step;
    logic [DIM_W-1:0]  col;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DIM_W:0]    col_x, k_x, w_x, h_x, r_x;

    assign col_x = {1'b0, col};
    assign k_x   = {1'b0, k_q};
    assign w_x   = {1'b0, w_q};
    assign h_x   = {1'b0, h_q};
    assign r_x   = {1'b0, r_q};

    // FSM next-state and counter strobes.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        w_d       = w_q;
        k_d       = k_q;
        r_d       = r_q;
        j_d       = j_q;
        err_d     = err_q;
        row_init  = 1'b0;
        col_init  = 1'b0;
        slot_step = 1'b0;
        col_next  = 1'b0;
        row_next  = 1'b0;
        wr_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    h_d = i_h;
                    w_d = i_w;
                    k_d = i_n;
                    if (legal_geometry(i_h, i_w, i_n, MAX_N)) begin
                        err_d    = 1'b0;
                        row_init = 1'b1;
                        r_d      = '0;
                        state_d  = CLEAR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                col_init = 1'b1;
                j_d      = '0;
                state_d  = FEED;
            end
            FEED: begin
                if (j_q == LAST_J) begin
                    j_d = '0;
                    // Columns before the first full window chain straight into the next column.
                    if (col_x + 1'b1 < k_x) begin
                        col_next = 1'b1;
                    end else begin
                        state_d = SETTLE;
                    end
                end else begin
                    j_d       = j_q + 1'b1;
                    slot_step = 1'b1;
                end
            end
            SETTLE: begin
                state_d = WRITE;
            end
            WRITE: begin
                wr_step = 1'b1;
                if (col_x + 1'b1 == w_x) begin
                    r_d      = r_q + 1'b1;
                    row_next = 1'b1;
                    state_d  = (r_x + 1'b1 <= h_x - k_x) ? CLEAR : DONE;
                end else begin
                    col_next = 1'b1;
                    j_d      = '0;
                    state_d  = FEED;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Each FEED slot pushes into the kernel one cycle later, when its read data arrives.
        ken_d = (state_q == FEED);
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            w_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
            ken_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            w_q     <= w_d;
            k_q     <= k_d;
            r_q     <= r_d;
            j_q     <= j_d;
            err_q   <= err_d;
            ken_q   <= ken_d;
        end
    end

    wos_addr_gen #(
        .IMG_BASE (IMG_BASE),
        .OUT_BASE (OUT_BASE)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_w         (w_q),
        .i_row_init  (row_init),
        .i_col_init  (col_init),
        .i_slot_step (slot_step),
        .i_col_next  (col_next),
        .i_row_next  (row_next),
        .i_wr_step   (wr_step),
        .o_col       (col),
        .o_rd_addr   (rd_addr),
        .o_wr_addr   (wr_addr)
    );

    assign o_busy       = (state_q != IDLE);
    assign o_rd_en      = (state_q == FEED) && (DIM_W'(j_q) < k_q);
    assign o_wr_en      = (state_q == WRITE);
    assign o_kernel_clr = (state_q == CLEAR);
    assign o_done       = (state_q == DONE);
    assign o_kernel_en  = ken_q;
    assign o_err        = err_q;
    assign o_addr       = o_rd_en ? rd_addr : (o_wr_en ? wr_addr : '0);

`ifdef FILTER_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    // Busy-cycle counter: restarts on a legal start, saturates, holds while idle.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == IDLE && i_start && legal_geometry(i_h, i_w, i_n, MAX_N)) begin
            cycles_d = '0;
        end else if (state_q != IDLE && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_wos_filter_sequencer.sv
// Self-checking bench for wos_filter_sequencer (MAX_N = 5).
module tb_wos_filter_sequencer;

    localparam int          MAX_N    = 5;
    localparam logic [31:0] IMG_BASE = 32'h0;
    localparam logic [31:0] OUT_BASE = 32'h200;
    localparam int          LIMIT    = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_h = '0, i_w = '0, i_n = '0;
    logic        o_busy, o_rd_en, o_wr_en, o_kernel_en, o_kernel_clr, o_done, o_err;
    logic [31:0] o_addr;
`ifdef FILTER_PERF_EN
    logic [31:0] o_cycles;
`endif

    int tests = 0;
    int fails = 0;

    // Observed/expected memory event traces: bit 32 set = write, clear = read.
    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int busy_cnt, clr_cnt, ken_cnt, done_cnt, done_idx, first_ken, last_ken;
    bit ended;

    wos_filter_sequencer #(
        .MAX_N    (MAX_N),
        .IMG_BASE (IMG_BASE),
        .OUT_BASE (OUT_BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_h          (i_h),
        .i_w          (i_w),
        .i_n          (i_n),
        .o_busy       (o_busy),
        .o_addr       (o_addr),
        .o_rd_en      (o_rd_en),
        .o_wr_en      (o_wr_en),
        .o_kernel_en  (o_kernel_en),
        .o_kernel_clr (o_kernel_clr),
        .o_done       (o_done),
        .o_err        (o_err)
`ifdef FILTER_PERF_EN
        ,
        .o_cycles     (o_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input int h, input int w, input int k);
        return (k >= 1) && (k <= MAX_N) && (k <= h) && (k <= w);
    endfunction

    function automatic int rows_of(input int h, input int w, input int k);
        return legal(h, w, k) ? (h - k + 1) : 0;
    endfunction

    function automatic int exp_busy(input int h, input int w, input int k);
        if (!legal(h, w, k)) return 1;
        return rows_of(h, w, k) * (1 + w * MAX_N + 2 * (w - k + 1)) + 1;
    endfunction

    // Every window row: each column reads k pixels top to bottom; once a full
    // window exists, the column is followed by one dense output write.
    task automatic build_model(input int h, input int w, input int k);
        int idx;
        exp_q.delete();
        idx = 0;
        if (legal(h, w, k)) begin
            for (int r = 0; r <= h - k; r++) begin
                for (int c = 0; c < w; c++) begin
                    for (int j = 0; j < k; j++)
                        exp_q.push_back({1'b0, IMG_BASE + 32'((r + j) * w + c)});
                    if (c >= k - 1) begin
                        exp_q.push_back({1'b1, OUT_BASE + 32'(idx)});
                        idx++;
                    end
                end
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Issue one start and record everything until the DUT drops busy.
    // restart_at >= 0 re-pulses i_start (with different geometry) that many cycles in.
    task automatic run(input int h, input int w, input int k, input int restart_at);
        obs_q.delete();
        busy_cnt = 0; clr_cnt = 0; ken_cnt = 0; done_cnt = 0;
        done_idx = -1; first_ken = -1; last_ken = -1; ended = 1'b0;
        build_model(h, w, k);
        i_h = 8'(h); i_w = 8'(w); i_n = 8'(k); i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            if (!o_busy) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (o_rd_en) obs_q.push_back({1'b0, o_addr});
            if (o_wr_en) obs_q.push_back({1'b1, o_addr});
            if (o_kernel_clr) clr_cnt++;
            if (o_kernel_en) begin
                if (first_ken < 0) first_ken = cyc;
                last_ken = cyc;
                ken_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                done_idx = cyc;
            end
            i_start = (cyc == restart_at);
            if (cyc == restart_at) begin
                i_n = 8'd1; i_w = 8'd2; i_h = 8'd2;
            end
            tick();
        end
        i_start = 1'b0;
        $display("[TB] run h=%0d w=%0d k=%0d events=%0d busy=%0d err=%0b", h, w, k,
                 obs_q.size(), busy_cnt, o_err);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({o_busy, o_rd_en, o_wr_en, o_kernel_en, o_kernel_clr, o_done, o_err, o_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b ken=%b clr=%b done=%b err=%b addr=%h, want all 0",
                     o_busy, o_rd_en, o_wr_en, o_kernel_en, o_kernel_clr, o_done, o_err, o_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_h4_w4_k3();
        int d;
        run(4, 4, 3, -1);
        tests++; if (!ended) begin fails++; $display("FAIL k3_timeout: busy never dropped within %0d cycles", LIMIT); end
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL k3_trace: first difference at event %0d (got %0d events, want %0d)", d, obs_q.size(), exp_q.size()); end
        tests++; if (busy_cnt != 51) begin fails++; $display("FAIL k3_busy: got %0d cycles, want 51", busy_cnt); end
        tests++; if (done_cnt != 1 || done_idx != 50) begin fails++; $display("FAIL k3_done: got %0d pulses at %0d, want 1 at 50", done_cnt, done_idx); end
        tests++; if (clr_cnt != 2) begin fails++; $display("FAIL k3_clr: got %0d pulses, want 2", clr_cnt); end
        tests++; if (ken_cnt != 40 || first_ken != 2 || last_ken != 48) begin fails++; $display("FAIL k3_kernel_en: got count=%0d first=%0d last=%0d, want 40/2/48", ken_cnt, first_ken, last_ken); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL k3_err: got %b, want 0", o_err); end
`ifdef FILTER_PERF_EN
        tests++; if (o_cycles !== 32'd51) begin fails++; $display("FAIL perf_cycles: got %0d, want 51", o_cycles); end
        repeat (3) tick();
        tests++; if (o_cycles !== 32'd51) begin fails++; $display("FAIL perf_hold: got %0d, want 51", o_cycles); end
`endif
    endtask

    task automatic test_k1();
        int d;
        run(3, 3, 1, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL k1_trace: first difference at event %0d (got %0d events, want %0d)", d, obs_q.size(), exp_q.size()); end
        tests++; if (busy_cnt != exp_busy(3, 3, 1)) begin fails++; $display("FAIL k1_busy: got %0d, want %0d", busy_cnt, exp_busy(3, 3, 1)); end
        tests++; if (clr_cnt != 3) begin fails++; $display("FAIL k1_clr: got %0d, want 3", clr_cnt); end
    endtask

    task automatic test_illegal();
        int geo[3][3] = '{'{4, 4, 0}, '{8, 8, 6}, '{6, 4, 5}};
        for (int g = 0; g < 3; g++) begin
            run(geo[g][0], geo[g][1], geo[g][2], -1);
            tests++;
            if (o_err !== 1'b1 || obs_q.size() != 0 || busy_cnt != 1 || done_cnt != 1 || done_idx != 0) begin
                fails++;
                $display("FAIL illegal_k%0d: got err=%b events=%0d busy=%0d done=%0d@%0d, want err=1 events=0 busy=1 done=1@0",
                         geo[g][2], o_err, obs_q.size(), busy_cnt, done_cnt, done_idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        run(4, 4, 3, 7);
        d = first_diff();
        tests++; if (d != -1 || busy_cnt != 51) begin fails++; $display("FAIL restart_ignored: got diff=%0d busy=%0d, want -1/51", d, busy_cnt); end
        tick();
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL restart_idle: got busy=%b, want 0", o_busy); end
    endtask

    task automatic test_mid_reset();
        int d;
        i_h = 8'd4; i_w = 8'd4; i_n = 8'd3; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tests++;
        if ({o_busy, o_rd_en, o_wr_en, o_kernel_en, o_kernel_clr, o_done, o_err, o_addr} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b rd=%b wr=%b ken=%b clr=%b done=%b err=%b addr=%h, want all 0",
                     o_busy, o_rd_en, o_wr_en, o_kernel_en, o_kernel_clr, o_done, o_err, o_addr);
        end
        rst = 1'b0;
        tick();
        run(4, 4, 3, -1);
        d = first_diff();
        tests++; if (d != -1 || busy_cnt != 51 || ken_cnt != 40) begin fails++; $display("FAIL midreset_rerun: got diff=%0d busy=%0d ken=%0d, want -1/51/40", d, busy_cnt, ken_cnt); end
    endtask

    task automatic test_random();
        int h, w, k, d;
        for (int it = 0; it < 12; it++) begin
            h = $urandom_range(1, 8);
            w = $urandom_range(1, 8);
            k = $urandom_range(0, 6);
            if (it % 3 == 0) k = (h < w ? h : w) > MAX_N ? MAX_N : (h < w ? h : w);
            run(h, w, k, -1);
            d = first_diff();
            tests++; if (d != -1) begin fails++; $display("FAIL rand_trace h=%0d w=%0d k=%0d: first difference at %0d (got %0d events, want %0d)", h, w, k, d, obs_q.size(), exp_q.size()); end
            tests++; if (busy_cnt != exp_busy(h, w, k) || done_idx != exp_busy(h, w, k) - 1) begin fails++; $display("FAIL rand_timing h=%0d w=%0d k=%0d: got busy=%0d done@%0d, want %0d", h, w, k, busy_cnt, done_idx, exp_busy(h, w, k)); end
            tests++; if (o_err !== !legal(h, w, k) || clr_cnt != rows_of(h, w, k) || ken_cnt != rows_of(h, w, k) * w * MAX_N) begin fails++; $display("FAIL rand_misc h=%0d w=%0d k=%0d: got err=%b clr=%0d ken=%0d", h, w, k, o_err, clr_cnt, ken_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_h4_w4_k3();
        test_k1();
        test_illegal();
        test_h4_w4_k3();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
